dram_read_arbiter: RTL and testbench

- Shares one DRAMReader between NREQ requesters, each submitting (start address, byte count) read jobs.
- Round-robin selects a job, issues it on the reader's CONFIG port, then routes the reader's 64-bit data beats to the owning requester with a last-beat marker.
- Sits between the accelerator's DMA clients and the AXI read engine; it is the only master of the reader's CONFIG and DATA_READY_DOWNSTREAM.

---
 rtl/dram_pkg.sv | 24 ++
 rtl/dram_read_arbiter_rr_arbiter.sv | 51 +++++
 rtl/dram_read_arbiter.sv | 159 +++++++++++++++
 tb/tb_dram_read_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM reader arbitration blocks.
//   BURST_BYTES / BEAT_BYTES / BEATS_PER_BURST : reader burst geometry
//   BEAT_CNT_W                                 : width of the per-job beat counter
//   rd_state_e                                 : arbiter FSM states
//   beats_for()                                : byte count -> number of 64-bit beats
package dram_pkg;

  localparam int BURST_BYTES     = 128;
  localparam int BEAT_BYTES      = 8;
  localparam int BEATS_PER_BURST = BURST_BYTES / BEAT_BYTES;
  localparam int BEAT_CNT_W      = 29;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2
  } rd_state_e;

  // The reader only moves whole 128-byte bursts; any sub-burst remainder is dropped.
  function automatic logic [BEAT_CNT_W-1:0] beats_for(input logic [31:0] nbytes);
    return {nbytes[31:7], 4'b0000};
  endfunction

endpackage

// File: rtl/dram_read_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   start_idx   : first index to consider (search wraps upward from here)
//   grant       : one-hot grant (zero when nothing requests)
//   grant_idx   : index of the granted requester
//   grant_valid : some requester was granted
module rr_arbiter
  import dram_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start_idx,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_valid
);

  // rot_idx[k] is the requester examined at priority position k.
  logic [IDW-1:0] rot_idx [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [IDW:0] sum;
      assign sum = {1'b0, start_idx} + (IDW+1)'(gi);
      assign rot_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                    : sum[IDW-1:0];
    end
  endgenerate

  // Walk priority positions from lowest to highest priority so the
  // highest-priority active request overwrites everything before it.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && (rot_idx[k] == IDW'(j))) begin
          grant       = '0;
          grant[j]    = 1'b1;
          grant_idx   = IDW'(j);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dram_read_arbiter.sv
// Shares one DRAM reader between NREQ requesters.
//   REQ_*          : per-requester (start address, byte count) jobs, valid/ready
//   CONFIG_*       : job issued to the reader's CONFIG port
//   RD_DATA_*      : reader data stream (RD_DATA_READY drives DATA_READY_DOWNSTREAM)
//   OUT_*          : data beats routed to the owning requester, OUT_LAST on the final beat
//   BUSY, GRANT_ID : status / current owner
// Jobs are picked round-robin in IDLE, issued in ISSUE, and streamed with
// zero-latency pass-through backpressure in STREAM.
module dram_read_arbiter
  import dram_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [NREQ-1:0]        REQ_VALID,
  output logic [NREQ-1:0]        REQ_READY,
  input  logic [32*NREQ-1:0]     REQ_START_ADDR,
  input  logic [32*NREQ-1:0]     REQ_NBYTES,
  output logic                   CONFIG_VALID,
  input  logic                   CONFIG_READY,
  output logic [31:0]            CONFIG_START_ADDR,
  output logic [31:0]            CONFIG_NBYTES,
  input  logic                   RD_DATA_VALID,
  output logic                   RD_DATA_READY,
  input  logic [63:0]            RD_DATA,
  output logic [NREQ-1:0]        OUT_VALID,
  input  logic [NREQ-1:0]        OUT_READY,
  output logic [63:0]            OUT_DATA,
  output logic                   OUT_LAST,
  output logic                   BUSY,
  output logic [IDW-1:0]         GRANT_ID
);

  rd_state_e             state_reg, state_next;
  logic [IDW-1:0]        ptr_reg, ptr_next;          // next index to search from
  logic [IDW-1:0]        grant_id_reg, grant_id_next;
  logic [BEAT_CNT_W-1:0] beats_reg, beats_next;
  logic [31:0]           addr_reg, addr_next;
  logic [31:0]           nbytes_reg, nbytes_next;

  logic [NREQ-1:0]       arb_grant;
  logic [IDW-1:0]        arb_idx;
  logic                  arb_valid;
  logic [31:0]           sel_addr, sel_nbytes;
  logic [NREQ-1:0]       owner_onehot;
  logic                  owner_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req         (REQ_VALID),
    .start_idx   (ptr_reg),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_owner
      assign owner_onehot[gi] = (grant_id_reg == IDW'(gi));
    end
  endgenerate

  assign owner_ready = |(OUT_READY & owner_onehot);

  // Job fields of the current arbitration winner.
  always_comb begin
    sel_addr   = '0;
    sel_nbytes = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (arb_grant[j]) begin
        sel_addr   = REQ_START_ADDR[32*j +: 32];
        sel_nbytes = REQ_NBYTES[32*j +: 32];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      grant_id_reg <= '0;
      beats_reg    <= '0;
      addr_reg     <= '0;
      nbytes_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grant_id_reg <= grant_id_next;
      beats_reg    <= beats_next;
      addr_reg     <= addr_next;
      nbytes_reg   <= nbytes_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grant_id_next = grant_id_reg;
    beats_next    = beats_reg;
    addr_next     = addr_reg;
    nbytes_next   = nbytes_reg;
    REQ_READY     = '0;
    CONFIG_VALID  = 1'b0;
    RD_DATA_READY = 1'b0;
    OUT_VALID     = '0;
    OUT_LAST      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          REQ_READY     = arb_grant;
          addr_next     = sel_addr;
          nbytes_next   = sel_nbytes;
          grant_id_next = arb_idx;
          // The winner drops to lowest priority for the next round.
          ptr_next      = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
          beats_next    = beats_for(sel_nbytes);
          // A sub-burst job would hang the reader: complete it here with no beats.
          if (sel_nbytes[31:7] != '0) begin
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        CONFIG_VALID = 1'b1;
        if (CONFIG_READY) begin
          state_next = STREAM;
        end
      end

      STREAM: begin
        OUT_VALID     = owner_onehot & {NREQ{RD_DATA_VALID}};
        RD_DATA_READY = owner_ready;
        OUT_LAST      = RD_DATA_VALID && (beats_reg == BEAT_CNT_W'(1));
        if (RD_DATA_VALID && owner_ready) begin
          beats_next = beats_reg - BEAT_CNT_W'(1);
          if (beats_reg == BEAT_CNT_W'(1)) begin
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign CONFIG_START_ADDR = addr_reg;
  assign CONFIG_NBYTES     = nbytes_reg;
  assign OUT_DATA          = RD_DATA;
  assign BUSY              = (state_reg != IDLE);
  assign GRANT_ID          = grant_id_reg;

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Randomized self-checking bench for dram_read_arbiter. The bench plays the
// requesters and the DRAM reader; a job-level reference model predicts grants,
// config issue, beat routing and last markers.
module tb_dram_read_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 3;

  logic                 ACLK = 1'b0;
  logic                 ARESETN;
  logic [NREQ-1:0]      REQ_VALID, REQ_READY;
  logic [32*NREQ-1:0]   REQ_START_ADDR, REQ_NBYTES;
  logic                 CONFIG_VALID, CONFIG_READY;
  logic [31:0]          CONFIG_START_ADDR, CONFIG_NBYTES;
  logic                 RD_DATA_VALID, RD_DATA_READY;
  logic [63:0]          RD_DATA;
  logic [NREQ-1:0]      OUT_VALID, OUT_READY;
  logic [63:0]          OUT_DATA;
  logic                 OUT_LAST, BUSY;
  logic [IDW-1:0]       GRANT_ID;

  always #5 ACLK = ~ACLK;

  dram_read_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .ACLK              (ACLK),
    .ARESETN           (ARESETN),
    .REQ_VALID         (REQ_VALID),
    .REQ_READY         (REQ_READY),
    .REQ_START_ADDR    (REQ_START_ADDR),
    .REQ_NBYTES        (REQ_NBYTES),
    .CONFIG_VALID      (CONFIG_VALID),
    .CONFIG_READY      (CONFIG_READY),
    .CONFIG_START_ADDR (CONFIG_START_ADDR),
    .CONFIG_NBYTES     (CONFIG_NBYTES),
    .RD_DATA_VALID     (RD_DATA_VALID),
    .RD_DATA_READY     (RD_DATA_READY),
    .RD_DATA           (RD_DATA),
    .OUT_VALID         (OUT_VALID),
    .OUT_READY         (OUT_READY),
    .OUT_DATA          (OUT_DATA),
    .OUT_LAST          (OUT_LAST),
    .BUSY              (BUSY),
    .GRANT_ID          (GRANT_ID)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pending jobs per requester (head is what the requester presents).
  logic [31:0] job_addr [NREQ][$];
  logic [31:0] job_nb   [NREQ][$];

  // Stimulus knobs (percent probabilities).
  int p_req = 100, p_rd = 100, p_ordy = 100, p_cfg = 100;
  bit ordy_toggle = 1'b0;
  int cfg_block = 0;
  int cyc = 0;

  // Reference model: job-level view.
  int          m_phase = 0;   // 0 no job, 1 waiting for reader config, 2 delivering beats
  int          m_ptr   = 0;   // first requester to consider next round
  int          m_owner = 0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_nb    = '0;
  int          m_left  = 0;
  int          m_done_beats = 0;

  // DRAM reader model.
  int          rd_left = 0;
  logic [31:0] rd_addr = '0;
  int          rd_idx  = 0;

  // Event counters.
  int c_cfg_cyc = 0, c_cfg_xfer = 0, c_last = 0, c_accept = 0, c_jobs_done = 0;
  int c_beats [NREQ];
  int grant_log [$];

  function automatic int pending();
    int n = (m_phase != 0) ? 1 : 0;
    for (int i = 0; i < NREQ; i++) n += job_addr[i].size();
    return n;
  endfunction

  // Runs at the falling edge: compare outputs against the model, then advance
  // the model by whatever handshakes complete at the coming rising edge.
  task automatic sample_cycle();
    logic [NREQ-1:0] exp_rr, exp_ov;
    int g, idx;
    exp_rr = '0;
    g = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && REQ_VALID[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rr[g] = 1'b1;
    check_val("req_ready", 64'(REQ_READY), 64'(exp_rr));
    check_val("busy", 64'(BUSY), 64'(m_phase != 0));
    check_val("grant_id", 64'(GRANT_ID), 64'(m_owner));
    check_val("config_valid", 64'(CONFIG_VALID), 64'(m_phase == 1));
    if (m_phase == 1) begin
      c_cfg_cyc++;
      check_val("config_addr", 64'(CONFIG_START_ADDR), 64'(m_addr));
      check_val("config_nbytes", 64'(CONFIG_NBYTES), 64'(m_nb));
    end
    exp_ov = '0;
    if (m_phase == 2 && RD_DATA_VALID) exp_ov[m_owner] = 1'b1;
    check_val("out_valid", 64'(OUT_VALID), 64'(exp_ov));
    check_val("rd_data_ready", 64'(RD_DATA_READY), 64'((m_phase == 2) ? OUT_READY[m_owner] : 1'b0));
    check_val("out_last", 64'(OUT_LAST), 64'(m_phase == 2 && RD_DATA_VALID && m_left == 1));
    if (OUT_LAST && RD_DATA_VALID && RD_DATA_READY) c_last++;

    // Reader consumes a beat whenever the DUT accepts one.
    if (RD_DATA_VALID && RD_DATA_READY && rd_left > 0) begin
      rd_left--;
      rd_idx++;
    end

    case (m_phase)
      0: if (g >= 0) begin
        m_addr  = job_addr[g].pop_front();
        m_nb    = job_nb[g].pop_front();
        m_owner = g;
        m_ptr   = (g + 1) % NREQ;
        c_accept++;
        grant_log.push_back(g);
        m_left = int'(m_nb / 128) * 16;
        m_done_beats = 0;
        if (m_left == 0) c_jobs_done++;
        else m_phase = 1;
      end
      1: if (CONFIG_READY) begin
        m_phase = 2;
        c_cfg_xfer++;
        rd_left = m_left;
        rd_addr = m_addr;
        rd_idx  = 0;
      end
      2: if (RD_DATA_VALID && OUT_READY[m_owner]) begin
        check_val("out_data", OUT_DATA, {m_addr, 32'(m_done_beats)});
        m_done_beats++;
        c_beats[m_owner]++;
        m_left--;
        if (m_left == 0) begin
          m_phase = 0;
          c_jobs_done++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive_cycle();
    for (int i = 0; i < NREQ; i++) begin
      if (job_addr[i].size() > 0) begin
        REQ_VALID[i] = ($urandom_range(99) < p_req);
        REQ_START_ADDR[32*i +: 32] = job_addr[i][0];
        REQ_NBYTES[32*i +: 32]     = job_nb[i][0];
      end else begin
        REQ_VALID[i] = 1'b0;
        REQ_START_ADDR[32*i +: 32] = '0;
        REQ_NBYTES[32*i +: 32]     = '0;
      end
    end
    if (cfg_block > 0) begin
      cfg_block--;
      CONFIG_READY = 1'b0;
    end else begin
      CONFIG_READY = (rd_left == 0) && ($urandom_range(99) < p_cfg);
    end
    RD_DATA_VALID = (rd_left > 0) && ($urandom_range(99) < p_rd);
    RD_DATA       = {rd_addr, 32'(rd_idx)};
    for (int i = 0; i < NREQ; i++) begin
      OUT_READY[i] = ordy_toggle ? ((cyc >> 1) & 1) != 0 : ($urandom_range(99) < p_ordy);
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge ACLK);
    sample_cycle();
    @(posedge ACLK);
    #1;
    drive_cycle();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((pending() != 0 || rd_left != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_val("drain_timeout", 64'(pending()), 64'd0);
    step();
    step();
  endtask

  task automatic add_job(input int r, input logic [31:0] a, input logic [31:0] nb);
    job_addr[r].push_back(a);
    job_nb[r].push_back(nb);
  endtask

  task automatic set_knobs(input int pr, input int prd, input int po, input int pc);
    p_req = pr; p_rd = prd; p_ordy = po; p_cfg = pc;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_req_ready"}, 64'(REQ_READY), 64'd0);
    check_val({tag, "_config_valid"}, 64'(CONFIG_VALID), 64'd0);
    check_val({tag, "_cfg_addr"}, 64'(CONFIG_START_ADDR), 64'd0);
    check_val({tag, "_cfg_nbytes"}, 64'(CONFIG_NBYTES), 64'd0);
    check_val({tag, "_rd_ready"}, 64'(RD_DATA_READY), 64'd0);
    check_val({tag, "_out_valid"}, 64'(OUT_VALID), 64'd0);
    check_val({tag, "_out_last"}, 64'(OUT_LAST), 64'd0);
    check_val({tag, "_busy"}, 64'(BUSY), 64'd0);
    check_val({tag, "_grant_id"}, 64'(GRANT_ID), 64'd0);
  endtask

  task automatic run_random(input int njobs);
    int d0 = c_jobs_done;
    int r;
    set_knobs(70, 60, 60, 50);
    for (int j = 0; j < njobs; j++) begin
      r = $urandom_range(NREQ - 1);
      add_job(r, $urandom, 32'($urandom_range(700)));
    end
    wait_done(40000);
    check_val("rand_jobs_done", 64'(c_jobs_done - d0), 64'(njobs));
    $display("random: %0d jobs, %0d comparisons so far", njobs, n_cmp);
  endtask

  initial begin
    int a0, cf0, cx0, b0, l0, n;
    for (int i = 0; i < NREQ; i++) c_beats[i] = 0;
    ARESETN = 1'b0;
    REQ_VALID = '0; REQ_START_ADDR = '0; REQ_NBYTES = '0;
    CONFIG_READY = 1'b0; RD_DATA_VALID = 1'b0; RD_DATA = '0; OUT_READY = '0;
    repeat (2) @(negedge ACLK);
    check_idle_outputs("reset");
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    drive_cycle();

    // Simultaneous requesters: alternate 0,1,0,1 from a fresh reset.
    grant_log.delete();
    add_job(0, 32'h0000_2000, 32'd128); add_job(1, 32'h0000_3000, 32'd128);
    add_job(0, 32'h0000_4000, 32'd128); add_job(1, 32'h0000_5000, 32'd128);
    wait_done(500);
    check_val("simul_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      for (int k = 0; k < 4; k++) check_val($sformatf("simul_order%0d", k), 64'(grant_log[k]), 64'(k % 2));
    end
    $display("simultaneous: grants %p", grant_log);

    // Single 256-byte job.
    a0 = c_accept; cf0 = c_cfg_cyc; b0 = c_beats[0]; l0 = c_last;
    add_job(0, 32'h0000_1000, 32'd256);
    wait_done(500);
    check_val("single_accepts", 64'(c_accept - a0), 64'd1);
    check_val("single_cfg_cycles", 64'(c_cfg_cyc - cf0), 64'd1);
    check_val("single_beats", 64'(c_beats[0] - b0), 64'd32);
    check_val("single_last", 64'(c_last - l0), 64'd1);
    check_val("single_busy_after", 64'(BUSY), 64'd0);
    $display("single: beats=%0d", c_beats[0] - b0);

    // Sub-burst job, then a rounded-down job.
    a0 = c_accept; cx0 = c_cfg_xfer; b0 = c_beats[2];
    add_job(2, 32'h0000_6000, 32'd100);
    wait_done(100);
    check_val("zero_accept", 64'(c_accept - a0), 64'd1);
    check_val("zero_cfg", 64'(c_cfg_xfer - cx0), 64'd0);
    check_val("zero_beats", 64'(c_beats[2] - b0), 64'd0);
    add_job(2, 32'h0000_7000, 32'd200);
    wait_done(200);
    check_val("round_cfg", 64'(c_cfg_xfer - cx0), 64'd1);
    check_val("round_beats", 64'(c_beats[2] - b0), 64'd16);
    $display("rounding: nbytes 100 -> 0 beats, nbytes 200 -> %0d beats", c_beats[2] - b0);

    // Downstream backpressure toggling every 2 cycles.
    ordy_toggle = 1'b1;
    b0 = c_beats[1]; l0 = c_last;
    add_job(1, 32'h0000_8000, 32'd128);
    wait_done(300);
    ordy_toggle = 1'b0;
    check_val("bp_beats", 64'(c_beats[1] - b0), 64'd16);
    check_val("bp_last", 64'(c_last - l0), 64'd1);
    $display("backpressure: beats=%0d", c_beats[1] - b0);

    // Reader not ready for 10 cycles.
    cf0 = c_cfg_cyc; cx0 = c_cfg_xfer;
    add_job(0, 32'h0000_9000, 32'd384);
    cfg_block = 10;
    wait_done(500);
    check_val("stall_cfg_cycles", 64'(c_cfg_cyc - cf0), 64'd10);
    check_val("stall_cfg_xfer", 64'(c_cfg_xfer - cx0), 64'd1);
    $display("config stall: config_valid cycles=%0d", c_cfg_cyc - cf0);

    // Reset after 5 of 16 beats.
    b0 = c_beats[1];
    add_job(1, 32'h0000_A000, 32'd128);
    n = 0;
    while (c_beats[1] - b0 < 5 && n < 200) begin
      step();
      n++;
    end
    check_val("mid_reset_reached", 64'(c_beats[1] - b0), 64'd5);
    #2;
    ARESETN = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    for (int i = 0; i < NREQ; i++) begin
      job_addr[i].delete();
      job_nb[i].delete();
    end
    m_phase = 0; m_ptr = 0; m_owner = 0; m_addr = '0; m_nb = '0; m_left = 0;
    rd_left = 0; rd_idx = 0;
    @(posedge ACLK); #1;
    drive_cycle();
    ARESETN = 1'b1;
    grant_log.delete();
    add_job(1, 32'h0000_B000, 32'd128);
    add_job(0, 32'h0000_C000, 32'd128);
    wait_done(500);
    check_val("post_reset_first_grant", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd0);
    $display("reset: first grant after release = %0d", (grant_log.size() > 0) ? grant_log[0] : -1);

    run_random(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
